// File: rtl/cache_controller.sv
// cache_controller: sequences one CPU load/store at a time between the CPU port, a direct-mapped
// 4-column write-through cache datapath (1-cycle read latency) and a word-wide backing memory.
//   - read hit : data straight from the cache in the lookup cycle
//   - read miss: refill the whole line from memory into a buffer, commit it to the cache, answer
//   - store    : write-through to memory; the cache is updated only on a hit (no write-allocate)
// Ports:
//   clk, rst                      single clock, synchronous active-high reset
//   cpu_*                         request/handshake side (cpu_done is a one-cycle pulse)
//   cache_*                       cache arrays: address, write word/enable, read word and hit flag
//   mem_*                         backing memory: enable/write/address/data, mem_ready per word
// Optional feature macro: CACHE_STATS_EN adds 32-bit hit_count / miss_count outputs.
module cache_controller #(
    parameter int unsigned LINE_IX_BITWIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_enable,
    input  logic        cpu_write_enable,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_data_in,
    output logic [31:0] cpu_data_out,
    output logic        cpu_done,
    output logic [31:0] cache_address,
    output logic [31:0] cache_data_in,
    output logic        cache_write_enable,
    input  logic [31:0] cache_data_out,
    input  logic        cache_data_out_valid,
    output logic        mem_enable,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_out,
    input  logic [31:0] mem_data_in,
    input  logic        mem_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int unsigned TagLsb = LINE_IX_BITWIDTH + 4;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StWriteMem,
        StRefill,
        StCommit,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [31:2] waddr_q, waddr_d;     // latched word address; byte offset is never needed
    logic [31:0] data_q, data_d;
    logic        write_q, write_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] buf_q [4];
    logic [31:0] buf_d [4];
    logic [31:0] result_q, result_d;
    logic [31:0] hit_q, hit_d;
    logic [31:0] miss_q, miss_d;
    logic [31:0] line_word_addr;

    // Same tag and line as the request, column taken from the word counter.
    assign line_word_addr = {waddr_q[31:TagLsb], waddr_q[TagLsb-1:4], cnt_q, 2'b00};

    always_comb begin
        state_d            = state_q;
        waddr_d            = waddr_q;
        data_d             = data_q;
        write_d            = write_q;
        cnt_d              = cnt_q;
        buf_d              = buf_q;
        result_d           = result_q;
        hit_d              = hit_q;
        miss_d             = miss_q;
        cpu_done           = 1'b0;
        cpu_data_out       = result_q;
        cache_address      = {waddr_q, 2'b00};
        cache_data_in      = data_q;
        cache_write_enable = 1'b0;
        mem_enable         = 1'b0;
        mem_write          = 1'b0;
        mem_address        = {waddr_q, 2'b00};
        mem_data_out       = data_q;

        unique case (state_q)
            StIdle: begin
                // Present the live address so the cache read completes during lookup.
                cache_address = cpu_address;
                if (cpu_enable) begin
                    waddr_d = cpu_address[31:2];
                    data_d  = cpu_data_in;
                    write_d = cpu_write_enable;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                if (cache_data_out_valid) hit_d = hit_q + 32'd1;
                else                      miss_d = miss_q + 32'd1;
                if (write_q) begin
                    cache_write_enable = cache_data_out_valid;
                    state_d            = StWriteMem;
                end else if (cache_data_out_valid) begin
                    cpu_done     = 1'b1;
                    cpu_data_out = cache_data_out;
                    result_d     = cache_data_out;
                    state_d      = StIdle;
                end else begin
                    cnt_d   = 2'd0;
                    state_d = StRefill;
                end
            end
            StWriteMem: begin
                mem_enable = 1'b1;
                mem_write  = 1'b1;
                if (mem_ready) begin
                    cpu_done = 1'b1;
                    state_d  = StIdle;
                end
            end
            StRefill: begin
                mem_enable  = 1'b1;
                mem_address = line_word_addr;
                if (mem_ready) begin
                    buf_d[cnt_q] = mem_data_in;
                    cnt_d        = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = StCommit;
                end
            end
            StCommit: begin
                cache_address      = line_word_addr;
                cache_write_enable = 1'b1;
                cache_data_in      = buf_q[cnt_q];
                cnt_d              = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = StDone;
            end
            StDone: begin
                cpu_done     = 1'b1;
                cpu_data_out = buf_q[waddr_q[3:2]];
                result_d     = buf_q[waddr_q[3:2]];
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            waddr_q  <= '0;
            data_q   <= '0;
            write_q  <= 1'b0;
            cnt_q    <= 2'd0;
            buf_q    <= '{default: '0};
            result_q <= '0;
            hit_q    <= '0;
            miss_q   <= '0;
        end else begin
            state_q  <= state_d;
            waddr_q  <= waddr_d;
            data_q   <= data_d;
            write_q  <= write_d;
            cnt_q    <= cnt_d;
            buf_q    <= buf_d;
            result_q <= result_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
        end
    end

`ifdef CACHE_STATS_EN
    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: drives cache_controller with directed and random loads/stores against a
// behavioural cache array, a wait-state memory and a flat reference model of memory contents,
// line residency, latency and the transfers each request must produce.
module tb_cache_controller;

    localparam int unsigned LineBits = 8;
    localparam int unsigned NumLines = 1 << LineBits;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_enable, cpu_write_enable;
    logic [31:0] cpu_address, cpu_data_in, cpu_data_out;
    logic        cpu_done;
    logic [31:0] cache_address, cache_data_in, cache_data_out;
    logic        cache_write_enable, cache_data_out_valid;
    logic        mem_enable, mem_write, mem_ready;
    logic [31:0] mem_address, mem_data_out, mem_data_in;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    cache_controller #(.LINE_IX_BITWIDTH(LineBits)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .cpu_enable          (cpu_enable),
        .cpu_write_enable    (cpu_write_enable),
        .cpu_address         (cpu_address),
        .cpu_data_in         (cpu_data_in),
        .cpu_data_out        (cpu_data_out),
        .cpu_done            (cpu_done),
        .cache_address       (cache_address),
        .cache_data_in       (cache_data_in),
        .cache_write_enable  (cache_write_enable),
        .cache_data_out      (cache_data_out),
        .cache_data_out_valid(cache_data_out_valid),
        .mem_enable          (mem_enable),
        .mem_write           (mem_write),
        .mem_address         (mem_address),
        .mem_data_out        (mem_data_out),
        .mem_data_in         (mem_data_in),
        .mem_ready           (mem_ready)
`ifdef CACHE_STATS_EN
        ,
        .hit_count           (hit_count),
        .miss_count          (miss_count)
`endif
    );

    // Cache datapath: direct-mapped, 4 columns, 1-cycle read, write sets tag and valid.
    logic [31:0] c_data [NumLines][4];
    logic [31:0] c_tag [NumLines];
    logic        c_valid [NumLines];
    logic        flush = 1'b0;
    wire [LineBits-1:0] c_line = cache_address[LineBits+3:4];
    wire [1:0]          c_col  = cache_address[3:2];
    wire [31:0]         c_tagv = cache_address >> (LineBits + 4);

    always @(posedge clk) begin
        if (flush) begin
            for (int i = 0; i < NumLines; i++) c_valid[i] <= 1'b0;
        end else begin
            cache_data_out       <= c_data[c_line][c_col];
            cache_data_out_valid <= c_valid[c_line] && (c_tag[c_line] == c_tagv);
            if (cache_write_enable) begin
                c_data[c_line][c_col] <= cache_data_in;
                c_tag[c_line]         <= c_tagv;
                c_valid[c_line]       <= 1'b1;
            end
        end
    end

    // Backing memory: window over address bits {16, 12:2}; unwritten words read a fixed pattern.
    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return 32'h9C + (a >> 2);
    endfunction

    logic [31:0] mem_arr [4096];
    logic        mem_set [4096];
    logic        mem_clr = 1'b0;
    int unsigned wait_cnt = 0;
    int unsigned wait_states = 0;
    wire [11:0]  m_idx = {mem_address[16], mem_address[12:2]};

    assign mem_ready = mem_enable && (wait_cnt == wait_states);
    always_comb mem_data_in = mem_set[m_idx] ? mem_arr[m_idx] : mem_init(mem_address);

    always @(posedge clk) begin
        if (!mem_enable || mem_ready) wait_cnt <= 0;
        else                          wait_cnt <= wait_cnt + 1;
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) mem_set[i] <= 1'b0;
        end else if (mem_enable && mem_ready && mem_write) begin
            mem_arr[m_idx] <= mem_data_out;
            mem_set[m_idx] <= 1'b1;
        end
    end

    // Transfer monitors.
    logic [64:0] mon_mem[$];
    logic [63:0] mon_cache[$];
    always @(posedge clk) begin
        if (!rst && mem_enable && mem_ready)
            mon_mem.push_back({mem_write, mem_address, mem_write ? mem_data_out : mem_data_in});
        if (!rst && cache_write_enable)
            mon_cache.push_back({cache_address[31:2], 2'b00, cache_data_in});
    end

    // Reference model.
    logic [31:0] ref_mem [logic [31:0]];
    bit          ref_valid [NumLines];
    logic [31:0] ref_tag [NumLines];
    logic [31:0] ref_hits = 0, ref_misses = 0;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
    endfunction

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request starting at a negedge with the DUT idle; returns at a negedge.
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int unsigned w);
        logic [31:0] wa, base, tg, exp_rd, rdata, a;
        int unsigned ln, exp_lat, lat, m0, c0, n;
        bit          hit, seen;
        logic [64:0] exp_mem[$];
        logic [63:0] exp_cache[$];
        wa     = {addr[31:2], 2'b00};
        base   = {addr[31:4], 4'b0000};
        ln     = 32'(addr[LineBits+3:4]);
        tg     = addr >> (LineBits + 4);
        hit    = ref_valid[ln] && (ref_tag[ln] == tg);
        exp_rd = ref_rd(wa);
        if (wr) begin
            exp_lat = 2 + w;
            exp_mem.push_back({1'b1, wa, wdata});
            if (hit) exp_cache.push_back({wa, wdata});
        end else if (hit) begin
            exp_lat = 1;
        end else begin
            exp_lat = 10 + 4 * w;
            for (int k = 0; k < 4; k++) begin
                a = base + 32'(4 * k);
                exp_mem.push_back({1'b0, a, ref_rd(a)});
                exp_cache.push_back({a, ref_rd(a)});
            end
        end

        wait_states      = w;
        m0               = mon_mem.size();
        c0               = mon_cache.size();
        cpu_enable       = 1'b1;
        cpu_write_enable = wr;
        cpu_address      = addr;
        cpu_data_in      = wdata;
        lat   = 0;
        seen  = 1'b0;
        rdata = '0;
        while (lat < 300 && !seen) begin
            @(negedge clk);
            lat++;
            if (cpu_done) begin
                seen  = 1'b1;
                rdata = cpu_data_out;
            end
        end
        cpu_enable = 1'b0;
        check_eq("done_seen", 64'(seen), 64'd1);
        check_eq("latency", 64'(lat), 64'(exp_lat));
        if (!wr) check_eq("rd_data", 64'(rdata), 64'(exp_rd));
        @(negedge clk);
        if (!wr) check_eq("rd_hold", 64'(cpu_data_out), 64'(exp_rd));

        check_eq("mem_n", 64'(mon_mem.size() - m0), 64'(exp_mem.size()));
        n = (mon_mem.size() - m0 < exp_mem.size()) ? mon_mem.size() - m0 : exp_mem.size();
        for (int i = 0; i < int'(n); i++)
            check_eq("mem_xfer", mon_mem[m0 + i][63:0] ^ {63'd0, mon_mem[m0 + i][64]},
                     exp_mem[i][63:0] ^ {63'd0, exp_mem[i][64]});
        for (int i = 0; i < int'(n); i++)
            check_eq("mem_dir", 64'(mon_mem[m0 + i][64]), 64'(exp_mem[i][64]));
        check_eq("cache_n", 64'(mon_cache.size() - c0), 64'(exp_cache.size()));
        n = (mon_cache.size() - c0 < exp_cache.size()) ? mon_cache.size() - c0 : exp_cache.size();
        for (int i = 0; i < int'(n); i++)
            check_eq("cache_wr", mon_cache[c0 + i], exp_cache[i]);

        if (hit) ref_hits++;
        else     ref_misses++;
        if (wr) ref_mem[wa] = wdata;
        else if (!hit) begin
            ref_valid[ln] = 1'b1;
            ref_tag[ln]   = tg;
        end
`ifdef CACHE_STATS_EN
        check_eq("hit_count", 64'(hit_count), 64'(ref_hits));
        check_eq("miss_count", 64'(miss_count), 64'(ref_misses));
`endif
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] tags [3];
        tags             = '{32'h0, 32'h1, 32'h10};
        rst              = 1'b1;
        cpu_enable       = 1'b0;
        cpu_write_enable = 1'b0;
        cpu_address      = '0;
        cpu_data_in      = '0;
        flush            = 1'b1;
        mem_clr          = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_done", 64'(cpu_done), 64'd0);
        check_eq("rst_mem_en", 64'(mem_enable), 64'd0);
        check_eq("rst_mem_wr", 64'(mem_write), 64'd0);
        check_eq("rst_cache_we", 64'(cache_write_enable), 64'd0);
        check_eq("rst_data", 64'(cpu_data_out), 64'd0);
        rst     = 1'b0;
        flush   = 1'b0;
        mem_clr = 1'b0;
        @(negedge clk);

        do_req(1'b0, 32'h0000_0010, 32'h0, 0);          // cold miss, 0xA0
        do_req(1'b0, 32'h0000_0014, 32'h0, 0);          // hit, 0xA1
        do_req(1'b1, 32'h0000_0018, 32'hDEAD_BEEF, 0);  // write hit
        do_req(1'b0, 32'h0000_0018, 32'h0, 0);          // hit, 0xDEADBEEF
        do_req(1'b1, 32'h0001_0010, 32'h1234_5678, 0);  // write miss, other tag
        do_req(1'b0, 32'h0000_0010, 32'h0, 0);          // still a hit
        do_req(1'b0, 32'h0000_0040, 32'h0, 2);          // miss, ready every third cycle
        do_req(1'b1, 32'h0000_0044, 32'h0BAD_F00D, 1);  // write hit with a wait state

        // Reset during the second refill word.
        wait_states      = 0;
        cpu_enable       = 1'b1;
        cpu_write_enable = 1'b0;
        cpu_address      = 32'h0000_0080;
        repeat (3) @(negedge clk);
        check_eq("refill_active", 64'(mem_enable), 64'd1);
        rst        = 1'b1;
        cpu_enable = 1'b0;
        flush      = 1'b1;
        @(negedge clk);
        check_eq("abort_mem_en", 64'(mem_enable), 64'd0);
        check_eq("abort_done", 64'(cpu_done), 64'd0);
        check_eq("abort_cache_we", 64'(cache_write_enable), 64'd0);
        check_eq("abort_data", 64'(cpu_data_out), 64'd0);
`ifdef CACHE_STATS_EN
        check_eq("abort_hits", 64'(hit_count), 64'd0);
        check_eq("abort_misses", 64'(miss_count), 64'd0);
`endif
        rst   = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < NumLines; i++) ref_valid[i] = 1'b0;
        ref_hits   = 0;
        ref_misses = 0;
        @(negedge clk);
        do_req(1'b0, 32'h0000_0084, 32'h0, 0);

        for (int t = 0; t < 150; t++) begin
            ra = (tags[$urandom_range(0, 2)] << 12) | (32'($urandom_range(0, 3)) << 4)
                 | 32'($urandom_range(0, 15));
            do_req(($urandom_range(0, 2) == 0), ra, $urandom, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
# cache_controller

Sequencer that sits between the CPU load/store port and the direct-mapped, 4-column write-through `Cache` datapath plus backing memory. It accepts one CPU request at a time, performs a tag lookup through the cache arrays, and handles each outcome:
- serves read hits directly from the cache;
- refills whole lines from memory on read misses;
- writes through to memory on every store, updating the cache only on a hit.

## Interface
Parameters:
- `LINE_IX_BITWIDTH`, 8, line index width; must equal the attached cache's value.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_enable`  in  1  request; held with stable address/data/write until `cpu_done`.
- `cpu_write_enable`  in  1  1 = store, 0 = load.
- `cpu_address`  in  32  byte address; bits [1:0] ignored.
- `cpu_data_in`  in  32  store data.
- `cpu_data_out`  out  32  load data, valid while `cpu_done`=1.
- `cpu_done`  out  1  one-cycle completion pulse.
- `cache_address`  out  32  address to cache.
- `cache_data_in`  out  32  word to cache.
- `cache_write_enable`  out  1  cache word+tag write.
- `cache_data_out`  in  32  cache read word (1-cycle read latency).
- `cache_data_out_valid`  in  1  hit flag, aligned with `cache_data_out`.
- `mem_enable`  out  1  memory transfer request.
- `mem_write`  out  1  1 = write, 0 = read.
- `mem_address`  out  32  word-aligned byte address.
- `mem_data_out`  out  32  write data.
- `mem_data_in`  in  32  read data, valid when `mem_ready`.
- `mem_ready`  in  1  completes the current word transfer this cycle.

## Operation
Address split:
- column [3:2].
- line [LINE_IX_BITWIDTH+3:4].
- tag = remaining upper bits.

States: IDLE, LOOKUP, WRITE_MEM, REFILL, COMMIT, DONE.
- IDLE: `cache_address` = `cpu_address` combinationally. On `cpu_enable`, latch address, data and write flag, then go to LOOKUP.
- LOOKUP: `cache_address` = latched address; `cache_data_out_valid` decides the path.
  - Read hit: `cpu_done`=1, `cpu_data_out`=`cache_data_out`, next state IDLE.
  - Read miss: word counter `cnt`=0, next state REFILL.
  - Write hit: `cache_write_enable`=1 with `cache_data_in`=latched data, next state WRITE_MEM.
  - Write miss: no cache write (no write-allocate), next state WRITE_MEM.
- WRITE_MEM: `mem_enable`=1, `mem_write`=1, `mem_address`=latched address, `mem_data_out`=latched data. On `mem_ready`: `cpu_done`=1, next state IDLE.
- REFILL: `mem_enable`=1, `mem_write`=0, `mem_address`={tag,line,`cnt`,2'b00}.
  - On `mem_ready`: store `mem_data_in` in line buffer[`cnt`].
  - `cnt`==3 → `cnt`=0, next state COMMIT; otherwise `cnt`+1, stay in REFILL.
  - `mem_enable` stays high across words.
- COMMIT: one word per cycle. `cache_address`={tag,line,`cnt`,2'b00}, `cache_write_enable`=1, `cache_data_in`=buffer[`cnt`]. After `cnt`==3, next state DONE.
- DONE: `cpu_done`=1, `cpu_data_out`=buffer[requested column], next state IDLE.

Rules:
- `cpu_enable` is ignored outside IDLE.
- `mem_ready` is ignored while `mem_enable`=0.
- The 2-bit `cnt` wraps 3→0.
- `cpu_data_out` outside `cpu_done` is the last result register value.

## Timing
Request accepted in cycle N (IDLE, `cpu_enable`=1).
- Read hit: `cpu_done` in N+1.
- Write: LOOKUP in N+1, WRITE_MEM from N+2; `cpu_done` in the cycle `mem_ready`=1 (N+2 if memory has no wait states).
- Read miss, no wait states: REFILL N+2..N+5, COMMIT N+6..N+9, `cpu_done` N+10. Each memory wait cycle adds one.
- A back-to-back request is accepted in the cycle after `cpu_done` at the earliest.

Reset values (the cycle after `rst` is sampled high):
- state IDLE, `cnt`=0, result register 0.
- `cpu_done`, `mem_enable`, `mem_write` and `cache_write_enable` all 0.

Reset mid-operation:
- Aborts to IDLE. Any memory transfer in flight is dropped, with `mem_enable` low on the next cycle.
- Reset during COMMIT can leave a line with a mix of new and stale columns under the new tag. System-level reset must also flush the cache.

## Configuration
- `CACHE_STATS_EN` defined: adds outputs `hit_count` and `miss_count`, each 32 bits, reset 0.
  - In LOOKUP, increments one counter per request (loads and stores).
  - Counters wrap modulo 2^32 and are not reset mid-operation except by `rst`.
- `CACHE_STATS_EN` not defined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Load 0x0000_0010, cold cache, memory returns 0xA0..0xA3 for 0x10..0x1C with `mem_ready` constant 1:
  - exactly 4 memory reads at 0x10, 0x14, 0x18, 0x1C;
  - 4 cache writes;
  - `cpu_done` at N+10 with data 0xA0.
- Repeat the load at 0x14: `cpu_done` at N+1, data 0xA1, no `mem_enable`.
- Store 0xDEAD_BEEF to 0x18 (hit), then load 0x18:
  - one cache write and one memory write, each with 0xDEADBEEF;
  - the load hits and returns 0xDEADBEEF.
- Store to 0x0001_0010 (same line, other tag): memory write only, no `cache_write_enable`; a subsequent load of 0x10 still hits.
- Refill with `mem_ready` high only every third cycle: `cpu_done` arrives 8 cycles later than the no-wait case, and data is correct.
- `rst` asserted during the second REFILL word:
  - next cycle IDLE with `mem_enable`=0 and `cpu_done`=0;
  - with `CACHE_STATS_EN`, counters are 0.
